// File: rtl/chan_sched.sv
// Left/right sequencer for a single shared mono audio engine: captures a sample pair,
// runs left then right through the engine, and publishes both results on one edge.
//
// state     | meaning
// IDLE      | waiting for a rising edge on valid
// LFT_START | one-cycle job start for the left sample, watchdog cleared
// LFT_WAIT  | waiting for eng_done (or watchdog expiry) on the left job
// RHT_START | one-cycle job start for the right sample, watchdog cleared
// RHT_WAIT  | waiting for eng_done (or watchdog expiry) on the right job
// UPDATE    | lft_out/rht_out just loaded together, out_upd high
module chan_sched #(
   parameter int DW      = 16,
   parameter int TIMEOUT = 1023
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          valid,
   input  logic [DW-1:0] lft_in,
   input  logic [DW-1:0] rht_in,
   output logic          eng_start,
   output logic          eng_sel,
   output logic [DW-1:0] eng_din,
   output logic          eng_abort,
   input  logic          eng_done,
   input  logic [DW-1:0] eng_dout,
   output logic [DW-1:0] lft_out,
   output logic [DW-1:0] rht_out,
   output logic          out_upd,
   input  logic          clr_flags,
   output logic          overrun,
   output logic          tmo
);

   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LFT_START = 3'd1,
      LFT_WAIT  = 3'd2,
      RHT_START = 3'd3,
      RHT_WAIT  = 3'd4,
      UPDATE    = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic          valid_q;
   logic [WW-1:0] wd_q, wd_d;
   logic [DW-1:0] lft_smp_q, lft_smp_d, rht_smp_q, rht_smp_d;
   logic [DW-1:0] lft_res_q, lft_res_d, rht_res_q, rht_res_d;
   logic [DW-1:0] lft_out_q, lft_out_d, rht_out_q, rht_out_d;
   logic          overrun_q, overrun_d, tmo_q, tmo_d;

   logic          vld_rise;
   logic          wait_st;
   logic          wd_expire;

   assign vld_rise  = valid & ~valid_q;
   assign wait_st   = (state_q == LFT_WAIT) || (state_q == RHT_WAIT);
   // done in the expiry cycle takes priority over the watchdog
   assign wd_expire = wait_st && (wd_q == WW'(TIMEOUT)) && !eng_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         valid_q   <= 1'b1;
         wd_q      <= '0;
         lft_smp_q <= '0;
         rht_smp_q <= '0;
         lft_res_q <= '0;
         rht_res_q <= '0;
         lft_out_q <= '0;
         rht_out_q <= '0;
         overrun_q <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid;
         wd_q      <= wd_d;
         lft_smp_q <= lft_smp_d;
         rht_smp_q <= rht_smp_d;
         lft_res_q <= lft_res_d;
         rht_res_q <= rht_res_d;
         lft_out_q <= lft_out_d;
         rht_out_q <= rht_out_d;
         overrun_q <= overrun_d;
         tmo_q     <= tmo_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      wd_d      = wd_q;
      lft_smp_d = lft_smp_q;
      rht_smp_d = rht_smp_q;
      lft_res_d = lft_res_q;
      rht_res_d = rht_res_q;
      lft_out_d = lft_out_q;
      rht_out_d = rht_out_q;
      case (state_q)
         IDLE: begin
            if (vld_rise) begin
               lft_smp_d = lft_in;
               rht_smp_d = rht_in;
               state_d   = LFT_START;
            end
         end
         LFT_START: begin
            wd_d    = '0;
            state_d = LFT_WAIT;
         end
         LFT_WAIT: begin
            wd_d = wd_q + WW'(1);
            if (eng_done) begin
               lft_res_d = eng_dout;
               state_d   = RHT_START;
            end else if (wd_expire) begin
               lft_res_d = lft_smp_q;
               state_d   = RHT_START;
            end
         end
         RHT_START: begin
            wd_d    = '0;
            state_d = RHT_WAIT;
         end
         RHT_WAIT: begin
            wd_d = wd_q + WW'(1);
            if (eng_done || wd_expire) begin
               rht_res_d = eng_done ? eng_dout : rht_smp_q;
               // both outputs load on the edge into UPDATE so the codec never sees a split pair
               lft_out_d = lft_res_q;
               rht_out_d = rht_res_d;
               state_d   = UPDATE;
            end
         end
         UPDATE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      overrun_d = (overrun_q & ~clr_flags) | (vld_rise && (state_q != IDLE));
      tmo_d     = (tmo_q & ~clr_flags) | wd_expire;
   end

   always_comb begin
      eng_start = (state_q == LFT_START) || (state_q == RHT_START);
      eng_sel   = (state_q == RHT_START) || (state_q == RHT_WAIT);
      eng_abort = wd_expire;
      out_upd   = (state_q == UPDATE);
      eng_din   = '0;
      if ((state_q == LFT_START) || (state_q == LFT_WAIT)) begin
         eng_din = lft_smp_q;
      end else if (eng_sel) begin
         eng_din = rht_smp_q;
      end
   end

   assign lft_out = lft_out_q;
   assign rht_out = rht_out_q;
   assign overrun = overrun_q;
   assign tmo     = tmo_q;

endmodule

// File: tb/tb_chan_sched.sv
// Directed bench for chan_sched: table of sample-pair jobs with scripted engine latency,
// plus hand sequences for reset behaviour and stray done pulses.
module tb_chan_sched;

   localparam int DW = 16;
   localparam int TO = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid;
   logic [DW-1:0] lft_in, rht_in;
   logic          eng_start, eng_sel, eng_abort, eng_done;
   logic [DW-1:0] eng_din, eng_dout;
   logic [DW-1:0] lft_out, rht_out;
   logic          out_upd, clr_flags, overrun, tmo;

   chan_sched #(.DW(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .valid(valid), .lft_in(lft_in), .rht_in(rht_in),
      .eng_start(eng_start), .eng_sel(eng_sel), .eng_din(eng_din), .eng_abort(eng_abort),
      .eng_done(eng_done), .eng_dout(eng_dout), .lft_out(lft_out), .rht_out(rht_out),
      .out_upd(out_upd), .clr_flags(clr_flags), .overrun(overrun), .tmo(tmo)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] prev_l = '0;
   logic [DW-1:0] prev_r = '0;

   // lw/rw: WAIT cycle in which done arrives (0 = never); ovr: cycle of a second valid rise; clr: cycle of clr_flags
   typedef struct {
      logic [DW-1:0] l;
      logic [DW-1:0] r;
      int            lw;
      int            rw;
      int            ovr;
      int            clr;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int lwe, rwe, ld, rd, rs, upd;
      logic [DW-1:0] el, er;
      logic exp_start, exp_abort, exp_upd;
      lwe = (v.lw != 0) ? v.lw : TO + 1;
      rwe = (v.rw != 0) ? v.rw : TO + 1;
      ld  = (v.lw != 0) ? 1 + v.lw : -1;
      rs  = 2 + lwe;
      rd  = (v.rw != 0) ? rs + v.rw : -1;
      upd = 3 + lwe + rwe;
      el  = (v.lw != 0) ? v.l + 16'd1 : v.l;
      er  = (v.rw != 0) ? v.r + 16'd1 : v.r;

      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      check($sformatf("v%0d_flags_clr", idx), {30'd0, overrun, tmo}, 32'd0);
      valid  = 1'b1;
      lft_in = v.l;
      rht_in = v.r;

      for (int c = 1; c <= upd + 1; c++) begin
         step();
         valid     = (c == 1) || (v.ovr != 0 && c >= v.ovr);
         clr_flags = (c == v.clr);
         eng_done  = (c == ld) || (c == rd);
         eng_dout  = (c == ld) ? v.l + 16'd1 : v.r + 16'd1;
         #1;
         exp_start = (c == 1) || (c == rs);
         exp_abort = (v.lw == 0 && c == 1 + lwe) || (v.rw == 0 && c == rs + rwe);
         exp_upd   = (c == upd);
         check($sformatf("v%0d_c%0d_ctl", idx, c), {29'd0, eng_start, eng_abort, out_upd},
               {29'd0, exp_start, exp_abort, exp_upd});
         if (c < upd) begin
            check($sformatf("v%0d_c%0d_sel", idx, c), {31'd0, eng_sel}, {31'd0, c >= rs});
            check($sformatf("v%0d_c%0d_din", idx, c), {16'd0, eng_din}, {16'd0, (c >= rs) ? v.r : v.l});
         end
         check($sformatf("v%0d_c%0d_out", idx, c), {lft_out, rht_out},
               (c >= upd) ? {el, er} : {prev_l, prev_r});
         if (c == upd + 1) begin
            check($sformatf("v%0d_tmo", idx), {31'd0, tmo}, {31'd0, v.lw == 0 || v.rw == 0});
            check($sformatf("v%0d_overrun", idx), {31'd0, overrun}, {31'd0, v.ovr != 0});
         end
      end
      prev_l    = el;
      prev_r    = er;
      valid     = 1'b0;
      eng_done  = 1'b0;
      clr_flags = 1'b0;
      step();
   endtask

   initial begin
      vecs[0] = '{16'h1000, 16'h2000, 1, 1, 0, 0};
      vecs[1] = '{16'h0AAA, 16'h0555, 7, 3, 0, 0};
      vecs[2] = '{16'h0123, 16'hBEEE, 0, 1, 0, 0};
      vecs[3] = '{16'h4444, 16'h7777, 16, 2, 0, 0};
      vecs[4] = '{16'h3000, 16'h4000, 3, 5, 8, 0};
      vecs[5] = '{16'h5A5A, 16'hA5A5, 2, 2, 7, 7};
      vecs[6] = '{16'hFFFF, 16'h0000, 2, 0, 0, 20};
      vecs[7] = '{16'h0001, 16'h0002, 1, 1, 3, 0};

      rst = 1'b1; valid = 1'b1; lft_in = 16'h1111; rht_in = 16'h2222;
      eng_done = 1'b0; eng_dout = '0; clr_flags = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      check("rst_ctl", {26'd0, eng_start, eng_sel, eng_abort, out_upd, overrun, tmo}, 32'd0);
      check("rst_out", {lft_out, rht_out}, 32'd0);
      check("rst_din", {16'd0, eng_din}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("hold_valid_%0d", i), {31'd0, eng_start}, 32'd0);
      end
      valid = 1'b0;
      step();

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      eng_done = 1'b1;
      eng_dout = 16'hDEAD;
      step();
      eng_done = 1'b0;
      check("idle_done_upd", {31'd0, out_upd}, 32'd0);
      check("idle_done_out", {lft_out, rht_out}, {prev_l, prev_r});
      step();
      check("idle_done_start", {31'd0, eng_start}, 32'd0);

      valid = 1'b1; lft_in = 16'h3333; rht_in = 16'h4444;
      step();
      step();
      check("mid_wait_sel", {31'd0, eng_sel}, 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_ctl", {26'd0, eng_start, eng_sel, eng_abort, out_upd, overrun, tmo}, 32'd0);
      check("mid_rst_out", {lft_out, rht_out}, 32'd0);
      check("mid_rst_din", {16'd0, eng_din}, 32'd0);
      prev_l = '0;
      prev_r = '0;
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("mid_hold_valid_%0d", i), {31'd0, eng_start}, 32'd0);
      end
      valid = 1'b0;
      step();
      run_vec(vecs[0], 8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/chan_sched.md
# chan_sched

Sequencer that shares one mono audio-processing engine (filter/effects core) between the left and right channels. It sits between the codec serial interface and the shared engine. On each new sample-pair strobe it captures both input samples and issues them to the engine one at a time, left first. It then presents the processed pair to the codec interface as a single coherent update. A watchdog covers a stalled engine, and sticky flags record dropped strobes and timeouts.

## Interface
Parameters:
- DW, 16, sample width in bits (all sample/result buses)
- TIMEOUT, 1023, max cycles waited for eng_done per channel; watchdog width = clog2(TIMEOUT+1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- valid  in  DW-independent 1  sample-pair strobe from codec interface; level may stay high many cycles, only rising edge used
- lft_in  in  DW  left sample from codec interface, stable while valid high
- rht_in  in  DW  right sample from codec interface, stable while valid high
- eng_start  out  1  one-cycle job start to engine
- eng_sel  out  1  channel of current job: 0 left, 1 right
- eng_din  out  DW  sample for current job, stable from eng_start until job ends
- eng_abort  out  1  one-cycle pulse: engine must drop current job
- eng_done  in  1  one-cycle completion pulse from engine
- eng_dout  in  DW  engine result, valid with eng_done
- lft_out  out  DW  processed left sample to codec interface
- rht_out  out  DW  processed right sample to codec interface
- out_upd  out  1  one-cycle pulse: lft_out/rht_out just updated
- clr_flags  in  1  clears overrun and tmo
- overrun  out  1  sticky: strobe arrived while busy and was dropped
- tmo  out  1  sticky: engine watchdog expired at least once

## Operation
- Edge detect: valid_q register; vld_rise = valid & ~valid_q. valid_q resets to 1, so valid held high across reset is not an edge.
- States: IDLE, LFT_START, LFT_WAIT, RHT_START, RHT_WAIT, UPDATE. Moore decode: eng_start = LFT_START|RHT_START; eng_sel = 1 in RHT_*; out_upd = UPDATE.
- IDLE: on vld_rise, capture lft_in→lft_smp and rht_in→rht_smp, then go to LFT_START.
- LFT_START: drive eng_din = lft_smp and clear the watchdog, then go to LFT_WAIT.
- LFT_WAIT: watchdog increments each cycle.
  - On eng_done: lft_res ← eng_dout, go to RHT_START.
  - If the watchdog equals TIMEOUT and eng_done is low: lft_res ← lft_smp (bypass), assert eng_abort, set tmo, go to RHT_START.
- RHT_START / RHT_WAIT: mirror of the left states, using rht_smp and rht_res. Exit to UPDATE.
- Entering UPDATE: lft_out ← lft_res and rht_out ← rht_res on the same edge, so they are never split. UPDATE lasts 1 cycle, then go to IDLE.
- Outputs hold between updates.
- eng_done is sampled only in the WAIT states; a pulse seen in any other state is ignored.

## Timing
- Reset values:
  - state IDLE, all data registers and outputs 0.
  - eng_start, eng_abort, out_upd, overrun, tmo = 0; eng_sel = 0.
- Reset mid-job returns to IDLE next edge; the engine shares rst and no abort pulse is issued.
- Latency: vld_rise in cycle t → LFT_START t+1 → LFT_WAIT t+2.
  - With a 1-cycle engine (done in the first WAIT cycle), out_upd is high in cycle t+5 and the new outputs are visible in the same cycle.
  - In general, latency = 5 + (left wait cycles − 1) + (right wait cycles − 1).
- Watchdog: timeout fires in the WAIT cycle where the count equals TIMEOUT, i.e. after TIMEOUT+1 WAIT cycles without done.
- Simultaneous events:
  - eng_done together with watchdog expiry: done wins, no tmo, no abort.
  - vld_rise in any state other than IDLE (including UPDATE): strobe dropped, overrun set.
  - clr_flags together with a set event: set wins.
- A vld_rise in the IDLE cycle right after UPDATE is accepted.

## Test plan
- Basic pass-through: engine model returns din+1 with 1-cycle latency; valid rises with lft_in=0x1000, rht_in=0x2000 → eng_sel 0 then 1, lft_out=0x1001, rht_out=0x2001, out_upd exactly one cycle at t+5.
- Variable latency: left done after 7 WAIT cycles, right after 3 → out_upd at t+13; outputs change only at out_upd and change together.
- Timeout: TIMEOUT=15, engine never answers on left, answers right with 0xBEEF; lft_in=0x0123 → eng_abort after 16 WAIT cycles, lft_out=0x0123, rht_out=0xBEEF, tmo=1.
- Done/expiry collision: eng_done in the exact expiry cycle → result taken from eng_dout, tmo stays 0, no abort.
- Overrun: second valid rise while in RHT_WAIT → overrun=1, only one out_upd; clr_flags with no new event → overrun=0; clr_flags in the same cycle as a new overrun → overrun stays 1.
- Reset: assert rst during LFT_WAIT → next cycle IDLE and all outputs 0; hold valid high through reset release → no job starts until valid falls and rises again.
